// File: rtl/ram_stream_reader.sv
// Burst read initiator for one block-RAM port: turns (addr, len) commands into RAM reads and a valid/ready stream.
// Optional read-and-clear behaviour is enabled by defining RAM_READER_CLEAR_EN.
module ram_stream_reader #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 64,
  parameter int               LG_DEPTH  = 6,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [LG_DEPTH-1:0] cmd_addr,
  input  logic [LG_DEPTH:0]   cmd_len,
  output logic                ram_en,
  output logic                ram_we,
  output logic [LG_DEPTH-1:0] ram_addr,
  output logic [WIDTH-1:0]    ram_din,
  input  logic [WIDTH-1:0]    ram_dout,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [WIDTH-1:0]    m_data,
  output logic                m_last,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [LG_DEPTH-1:0] ADDR_ONE = 1;
  localparam logic [LG_DEPTH:0]   REM_ONE  = 1;
  localparam logic [1:0]          CNT_ONE  = 1;

  state_t              state_q, state_d;
  logic [LG_DEPTH-1:0] cur_addr_q, cur_addr_d;
  logic [LG_DEPTH:0]   remaining_q, remaining_d;
  logic                inflight_q, inflight_d;
  logic                inflight_last_q, inflight_last_d;
  logic [WIDTH-1:0]    fifo_data_q [2];
  logic [WIDTH-1:0]    fifo_data_d [2];
  logic                fifo_last_q [2];
  logic                fifo_last_d [2];
  logic                rd_ptr_q, rd_ptr_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic [1:0]          fifo_cnt_q, fifo_cnt_d;

  logic                cmd_fire;
  logic                issue;
  logic                pop;
  logic                push;
  logic                fifo_pop;
  logic [2:0]          occ_after_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_fire && cmd_len != '0) state_d = RUN;
      RUN:     if (issue && remaining_q == REM_ONE) state_d = DRAIN;
      DRAIN:   if (occ_after_pop == 3'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // While the FIFO is empty the word arriving from the RAM is shown directly,
  // which gives the one-clock ram_en -> m_valid latency.
  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    cmd_fire  = cmd_valid && cmd_ready;
    m_valid   = (fifo_cnt_q != 2'd0) || inflight_q;
    if (fifo_cnt_q != 2'd0) begin
      m_data = fifo_data_q[rd_ptr_q];
      m_last = fifo_last_q[rd_ptr_q];
    end else if (inflight_q) begin
      m_data = ram_dout;
      m_last = inflight_last_q;
    end else begin
      m_data = '0;
      m_last = 1'b0;
    end
    pop           = m_valid && m_ready;
    occ_after_pop = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue         = (state_q == RUN) && (remaining_q != '0) && (occ_after_pop < 3'd2);
    ram_en        = issue;
    ram_addr      = cur_addr_q;
`ifdef RAM_READER_CLEAR_EN
    ram_we        = issue;
    ram_din       = CLEAR_VAL;
`else
    ram_we        = 1'b0;
    ram_din       = '0;
`endif
  end

  always_comb begin
    cur_addr_d      = cur_addr_q;
    remaining_d     = remaining_q;
    fifo_data_d     = fifo_data_q;
    fifo_last_d     = fifo_last_q;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    fifo_cnt_d      = fifo_cnt_q;
    inflight_d      = issue;
    inflight_last_d = issue && (remaining_q == REM_ONE);
    if (cmd_fire) begin
      cur_addr_d  = cmd_addr;
      remaining_d = cmd_len;
    end
    if (issue) begin
      cur_addr_d  = cur_addr_q + ADDR_ONE;
      remaining_d = remaining_q - REM_ONE;
    end
    // A bypassed word consumed in its arrival cycle never enters the FIFO.
    fifo_pop = pop && (fifo_cnt_q != 2'd0);
    push     = inflight_q && !(pop && (fifo_cnt_q == 2'd0));
    if (push) begin
      fifo_data_d[wr_ptr_q] = ram_dout;
      fifo_last_d[wr_ptr_q] = inflight_last_q;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (fifo_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    unique case ({push, fifo_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_ONE;
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_ONE;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr_q      <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_data_q[0]  <= '0;
      fifo_data_q[1]  <= '0;
      fifo_last_q[0]  <= 1'b0;
      fifo_last_q[1]  <= 1'b0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      fifo_cnt_q      <= 2'd0;
    end else begin
      cur_addr_q      <= cur_addr_d;
      remaining_q     <= remaining_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      fifo_data_q     <= fifo_data_d;
      fifo_last_q     <= fifo_last_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      fifo_cnt_q      <= fifo_cnt_d;
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader: a behavioural RAM image predicts every streamed word and RAM address,
// and a negedge monitor compares whatever the DUT presents against the queued predictions.
module tb_ram_stream_reader;

  localparam int         WIDTH     = 8;
  localparam int         DEPTH     = 64;
  localparam int         LG_DEPTH  = 6;
  localparam logic [7:0] CLEAR_VAL = 8'hA5;
`ifdef RAM_READER_CLEAR_EN
  localparam logic       CLEAR_EN  = 1'b1;
`else
  localparam logic       CLEAR_EN  = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic [LG_DEPTH-1:0] cmd_addr = '0;
  logic [LG_DEPTH:0]   cmd_len = '0;
  logic                ram_en;
  logic                ram_we;
  logic [LG_DEPTH-1:0] ram_addr;
  logic [WIDTH-1:0]    ram_din;
  logic [WIDTH-1:0]    ram_dout = '0;
  logic                m_valid;
  logic                m_ready = 1'b0;
  logic [WIDTH-1:0]    m_data;
  logic                m_last;
  logic                busy;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } word_t;

  word_t      exp_q[$];
  logic [5:0] addr_q[$];
  int         errors = 0;
  int         checks = 0;
  int         ram_en_count = 0;
  int         pop_count = 0;
  logic [7:0] ref_mem [DEPTH];
  logic [7:0] ram [DEPTH];
  logic       ram_init_req = 1'b0;
  logic       rand_ready = 1'b0;

  ram_stream_reader #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .LG_DEPTH(LG_DEPTH), .CLEAR_VAL(CLEAR_VAL)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy)
  );

  always #5 clk = ~clk;

  // Read-first block RAM that holds its output when not enabled.
  initial begin
    forever begin
      @(posedge clk);
      if (ram_init_req) begin
        for (int i = 0; i < DEPTH; i++) ram[i] <= ref_mem[i];
      end else if (ram_en) begin
        ram_dout <= ram[ram_addr];
        if (ram_we) ram[ram_addr] <= ram_din;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: compares RAM accesses and stream words against the queues.
  initial begin
    logic       stall_prev;
    logic [7:0] prev_data;
    logic       prev_last;
    word_t      w;
    stall_prev = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (ram_en) begin
          ram_en_count++;
          if (addr_q.size() == 0) checkOutput("spurious_ram_en", 32'd1, 32'd0);
          else checkOutput("ram_addr", 32'(ram_addr), 32'(addr_q.pop_front()));
          checkOutput("ram_we", 32'(ram_we), 32'(CLEAR_EN));
`ifdef RAM_READER_CLEAR_EN
          checkOutput("ram_din", 32'(ram_din), 32'(CLEAR_VAL));
`endif
        end
        if (stall_prev) begin
          checkOutput("hold_valid", 32'(m_valid), 32'd1);
          checkOutput("hold_data", 32'(m_data), 32'(prev_data));
          checkOutput("hold_last", 32'(m_last), 32'(prev_last));
        end
        if (m_valid && m_ready) begin
          pop_count++;
          if (exp_q.size() == 0) begin
            checkOutput("spurious_word", 32'd1, 32'd0);
          end else begin
            w = exp_q.pop_front();
            checkOutput("m_data", 32'(m_data), 32'(w.data));
            checkOutput("m_last", 32'(m_last), 32'(w.last));
          end
        end
        stall_prev = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic loadRam(input logic randomFill);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = randomFill ? 8'($urandom) : 8'(i);
    ram_init_req = 1'b1;
    tick();
    ram_init_req = 1'b0;
  endtask

  // Waits for cmd_ready, predicts the burst from the RAM image, then completes the handshake.
  task automatic applyStimulus(input logic [5:0] addr, input logic [6:0] len);
    int    n;
    word_t w;
    logic [5:0] a;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 1000) begin
      tick();
      n++;
    end
    checkOutput("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < int'(len); i++) begin
      a = addr + 6'(i);
      w.data = ref_mem[a];
      w.last = (i == int'(len) - 1);
      exp_q.push_back(w);
      addr_q.push_back(a);
      if (CLEAR_EN) ref_mem[a] = CLEAR_VAL;
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (!(cmd_ready && exp_q.size() == 0) && n < 1000) begin
      tick();
      n++;
    end
    checkOutput("reach_idle", 32'(cmd_ready && exp_q.size() == 0), 32'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base_en;
    int base_pop;
    int n;

    // Reset values
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_ram_en", 32'(ram_en), 32'd0);
    checkOutput("rst_ram_we", 32'(ram_we), 32'd0);
    checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_m_last", 32'(m_last), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ram_addr", 32'(ram_addr), 32'd0);
    checkOutput("rst_m_data", 32'(m_data), 32'd0);
    tick();
    rst = 1'b0;
    loadRam(1'b0);

    // addr=4 len=4 at full rate, with latency checks
    m_ready = 1'b1;
    applyStimulus(6'd4, 7'd4);
    @(negedge clk);
    checkOutput("lat_ram_en", 32'(ram_en), 32'd1);
    checkOutput("lat_no_valid", 32'(m_valid), 32'd0);
    checkOutput("lat_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      checkOutput("burst_valid", 32'(m_valid), 32'd1);
      checkOutput("burst_last", 32'(m_last), 32'(k == 3));
    end
    waitIdle();

    // Address wrap
    applyStimulus(6'd62, 7'd4);
    waitIdle();

    // Back-pressure: only two reads may be outstanding
    m_ready = 1'b0;
    base_en = ram_en_count;
    applyStimulus(6'd10, 7'd3);
    for (int k = 0; k < 10; k++) tick();
    checkOutput("stall_ram_en_count", 32'(ram_en_count - base_en), 32'd2);
    m_ready = 1'b1;
    waitIdle();
    checkOutput("stall_total_reads", 32'(ram_en_count - base_en), 32'd3);

    // Zero-length command
    base_en = ram_en_count;
    applyStimulus(6'd20, 7'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("len0_cmd_ready", 32'(cmd_ready), 32'd1);
      checkOutput("len0_busy", 32'(busy), 32'd0);
      checkOutput("len0_m_valid", 32'(m_valid), 32'd0);
      tick();
    end
    checkOutput("len0_no_reads", 32'(ram_en_count - base_en), 32'd0);

    // Read twice: second pass shows CLEAR_VAL when clearing is built in
    applyStimulus(6'd8, 7'd2);
    waitIdle();
    applyStimulus(6'd8, 7'd2);
    waitIdle();

    // Reset in the middle of a burst
    loadRam(1'b0);
    base_pop = pop_count;
    applyStimulus(6'd0, 7'd8);
    n = 0;
    while (pop_count - base_pop < 2 && n < 100) begin
      tick();
      n++;
    end
    checkOutput("midburst_two_words", 32'(pop_count - base_pop >= 2), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    addr_q.delete();
    @(negedge clk);
    checkOutput("post_rst_m_valid", 32'(m_valid), 32'd0);
    checkOutput("post_rst_busy", 32'(busy), 32'd0);
    checkOutput("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();
    loadRam(1'b0);
    base_pop = pop_count;
    applyStimulus(6'd0, 7'd1);
    waitIdle();
    for (int k = 0; k < 4; k++) tick();
    checkOutput("post_rst_single_word", 32'(pop_count - base_pop), 32'd1);

    // Randomised commands with random back-pressure
    loadRam(1'b1);
    rand_ready = 1'b1;
    for (int c = 0; c < 25; c++) begin
      if ($urandom_range(0, 3) == 0)
        applyStimulus(6'($urandom_range(0, 63)), 7'($urandom_range(0, 2)));
      else
        applyStimulus(6'($urandom_range(0, 63)), 7'($urandom_range(1, 64)));
    end
    rand_ready = 1'b0;
    m_ready = 1'b1;
    waitIdle();
    for (int k = 0; k < 3; k++) tick();
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("addr_queue_empty", 32'(addr_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
